// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
// Pipeline sequencing controller for the 5-stage RISC-V core. It detects
// load-use hazards, ID-stage taken branches and multi-cycle data-memory
// accesses, and from them drives the load enables, flushes and bubbles of
// every pipeline register. The memory access uses a req/ack handshake that is
// guarded by a timeout watchdog.
//
// Parameters:
//   MEM_TIMEOUT  max cycles spent waiting for mem_ack_i before a forced release (>=2)
//   CNT_W        width of the performance counters
//
// Optional feature (macro HAZARD_CTRL_PERF_CNT_EN):
//   defined   -> stall_cycles_o / flush_count_o are live wrapping counters
//   undefined -> both ports are tied to 0 and no counter flops exist
//
// Ports:
//   clk_i, rst_i      clock (rising edge), asynchronous active-high reset
//   ifid_rs1_i/rs2_i  source registers of the instruction in IF/ID
//   idex_memread_i    MemRead bit of the ID/EX instruction
//   idex_rd_i         destination register of the ID/EX instruction
//   branch_taken_i    branch resolved taken in ID this cycle
//   exmem_memreq_i    EX/MEM instruction accesses data memory
//   mem_ack_i         data memory has completed the access
//   mem_start_o       request strobe to data memory
//   pc_write_o        PC load enable
//   ifid_write_o      IF/ID load enable
//   ifid_flush_o      clear IF/ID to a NOP
//   idex_bubble_o     zero the EX/MEM/WB control fields loaded into ID/EX
//   pipe_hold_o       freeze ID/EX and EX/MEM
//   memwb_bubble_o    zero the control fields loaded into MEM/WB
//   mem_err_o         sticky flag: a memory timeout has occurred
//   stall_cycles_o    count of cycles with a memory or load-use stall
//   flush_count_o     count of cycles in which IF/ID was flushed
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [4:0]       ifid_rs1_i,
   input  logic [4:0]       ifid_rs2_i,
   input  logic             idex_memread_i,
   input  logic [4:0]       idex_rd_i,
   input  logic             branch_taken_i,
   input  logic             exmem_memreq_i,
   input  logic             mem_ack_i,
   output logic             mem_start_o,
   output logic             pc_write_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_hold_o,
   output logic             memwb_bubble_o,
   output logic             mem_err_o,
   output logic [CNT_W-1:0] stall_cycles_o,
   output logic [CNT_W-1:0] flush_count_o
);

   localparam int               TMR_W    = $clog2(MEM_TIMEOUT + 1);
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MEM_TIMEOUT - 1);

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   state_e           r_state;
   logic [TMR_W-1:0] r_timer;
   logic             r_mem_err;

   logic w_in_wait;
   logic w_load_use;
   logic w_timeout;
   logic w_mem_stall;

   assign w_in_wait  = (r_state == ST_MEM_WAIT);

   // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
   assign w_load_use = idex_memread_i & (idex_rd_i != 5'd0) &
                       ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

   // The timer counts waiting cycles; an ack in the last allowed cycle wins.
   assign w_timeout  = w_in_wait & (r_timer == TMR_LAST) & ~mem_ack_i;

   // Release is zero-latency: the ack (or timeout) cycle itself is not a stall.
   assign w_mem_stall = (~w_in_wait & exmem_memreq_i & ~mem_ack_i) |
                        ( w_in_wait & ~mem_ack_i & ~w_timeout);

   // Pipeline control. Everything is forced low while reset is held so the
   // pipeline stays frozen, including an in-flight request being aborted.
   // NOTE: every output gets a default at the top of the block so no path
   // leaves one unassigned, which would otherwise infer a latch.
   always_comb begin
      mem_start_o    = 1'b0;
      pc_write_o     = 1'b0;
      ifid_write_o   = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_bubble_o  = 1'b0;
      pipe_hold_o    = 1'b0;
      memwb_bubble_o = 1'b0;
      mem_err_o      = 1'b0;
      if (!rst_i) begin
         mem_start_o = w_in_wait | exmem_memreq_i;
         mem_err_o   = r_mem_err | w_timeout;
         if (w_mem_stall) begin
            // Whole front end waits; MEM/WB receives bubbles until data returns.
            pipe_hold_o    = 1'b1;
            memwb_bubble_o = 1'b1;
         end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle and inject a bubble behind the load.
            idex_bubble_o  = 1'b1;
         end else if (branch_taken_i) begin
            pc_write_o     = 1'b1;
            ifid_write_o   = 1'b1;
            ifid_flush_o   = 1'b1;
         end else begin
            pc_write_o     = 1'b1;
            ifid_write_o   = 1'b1;
         end
      end
   end

   // Memory handshake FSM with timeout watchdog and sticky error flag.
   // NOTE: sequential state is updated with non-blocking assignments so all
   // flops sample their inputs from the same pre-edge values.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_RUN;
         r_timer   <= '0;
         r_mem_err <= 1'b0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (exmem_memreq_i & ~mem_ack_i) begin
                  r_state <= ST_MEM_WAIT;
                  r_timer <= TMR_W'(1);
               end
            end
            ST_MEM_WAIT: begin
               if (mem_ack_i | w_timeout) begin
                  r_state <= ST_RUN;
                  r_timer <= '0;
                  if (w_timeout) begin
                     r_mem_err <= 1'b1;
                  end
               end else begin
                  r_timer <= r_timer + TMR_W'(1);
               end
            end
            default: begin
               r_state <= ST_RUN;
               r_timer <= '0;
            end
         endcase
      end
   end

`ifdef HAZARD_CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] r_stall_cycles;
   logic [CNT_W-1:0] r_flush_count;

   // Both counters wrap naturally modulo 2^CNT_W.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stall_cycles <= '0;
         r_flush_count  <= '0;
      end else begin
         if (w_mem_stall | w_load_use) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
         end
         if (ifid_flush_o) begin
            r_flush_count <= r_flush_count + CNT_W'(1);
         end
      end
   end

   assign stall_cycles_o = r_stall_cycles;
   assign flush_count_o  = r_flush_count;
`else
   assign stall_cycles_o = '0;
   assign flush_count_o  = '0;
`endif

endmodule
